uart_transmitter: RTL and testbench

- Serial UART transmitter; the egress counterpart to uart_receiver on the same board clock.
- Accepts bytes over a valid/ready handshake, for example an echo of the receiver's data_byte/valid, into a small FIFO.
- Serialises each byte as 8N1, LSB first, on uart_txd. The line idles high.
- A bit period of CLKS_PER_BIT matches the receiver's timing, so the two can be looped back.

---
 rtl/uart_transmitter.sv | 168 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// Byte FIFO (power-of-two depth) with head-of-queue read and explicit occupancy count.
// Latency: a pushed byte is visible at head_dat the cycle after the push edge.
// Backpressure: the caller gates push_vld with count < DEPTH and pop_vld with count > 0.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// 8N1 UART transmitter, LSB first, idle-high line, fed from a small byte FIFO.
// Latency: uart_txd falls 2 edges after the accepting handshake when idle; frame = 10*CLKS_PER_BIT.
// Backpressure: data_ready low during reset or when the FIFO is full; no bypass into the shifter.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_valid,
    input  logic [7:0]                    data,
    output logic                          data_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    head_dat;
    logic          push;
    logic          pop;
    logic          baud_last;

    assign data_ready = !rst && (fifo_count < CW'(FIFO_DEPTH));
    assign push       = data_valid && data_ready;
    assign baud_last  = (baud_cnt == BAUD_LAST);
    assign pop        = (fifo_count != '0) &&
                        ((state == IDLE) || ((state == STOP) && baud_last));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat (data),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    // Line and busy flops follow the state register one cycle behind, so every
    // bit keeps its full CLKS_PER_BIT width and frames abut without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= head_dat;
                        state <= START;
                    end
                end
                START: begin
                    uart_txd <= 1'b0;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    uart_txd <= shift[bit_idx];
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    uart_txd <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= head_dat;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    uart_txd <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling edge; a line monitor decodes frames.
module tb_uart_transmitter;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_valid;
    logic [7:0] data;
    logic       data_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data       (data),
        .data_ready (data_ready),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic [7:0] dat;
        logic [0:9] line;   // line level per bit period, in time order
    } vec_t;

    vec_t       vecs [5];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         last_rst_cyc = -1;
    int         framing_err = 0;
    logic [7:0] rx_q[$];
    int         rx_start[$];
    logic [7:0] tx_list [16];
    int         stall [16];
    int         cnt_at [16];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) last_rst_cyc <= cyc;
    end

    // Frames overlapped by a reset are dropped; others are decoded at bit centres.
    initial begin : line_monitor
        int         st;
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge clk);
            if (uart_txd === 1'b0 && rst === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                b  = '0;
                for (int s = 1; s < 10 * CPB; s++) begin
                    @(negedge clk);
                    if (s == 1 && uart_txd !== 1'b0) ok = 1'b0;
                    if (s >= 5 && s <= 33 && (s % 4) == 1) b[(s - 5) / 4] = uart_txd;
                    if (s == 37 && uart_txd !== 1'b1) ok = 1'b0;
                end
                if (last_rst_cyc < st) begin
                    if (!ok) framing_err++;
                    rx_q.push_back(b);
                    rx_start.push_back(st);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic chk_ok(input string nm, input bit ok, input int act, input string want);
        n_chk++;
        if (!ok) $display("FAIL %s: got %0d, expected %s", nm, act, want);
        else n_pass++;
    endtask

    // Push one byte while idle and check every line sample of its frame.
    task automatic run_frame(input logic [7:0] d, input logic [0:9] line, input string nm);
        logic [3:0] got;
        int         busy_n;
        chk({nm, " ready idle"}, data_ready, 1);
        data_valid = 1'b1;
        data       = d;
        tick();
        data_valid = 1'b0;
        chk({nm, " count after push"}, fifo_count, 1);
        chk({nm, " txd before pop"}, uart_txd, 1);
        tick();
        chk({nm, " count after pop"}, fifo_count, 0);
        chk({nm, " txd 1 edge after pop"}, uart_txd, 1);
        tick();
        busy_n = 0;
        for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < CPB; s++) begin
                got[s] = uart_txd;
                if (tx_busy === 1'b1) busy_n++;
                tick();
            end
            chk($sformatf("%s bit%0d", nm, b), got, {4{line[b]}});
        end
        chk({nm, " busy cycles"}, busy_n, 10 * CPB);
        chk({nm, " busy after frame"}, tx_busy, 0);
        chk({nm, " txd after frame"}, uart_txd, 1);
    endtask

    // Present tx_list[0..n-1] with data_valid held, advancing on each handshake.
    task automatic stream(input int n, input string nm);
        int   idx;
        int   guard;
        logic acc;
        idx   = 0;
        guard = 0;
        for (int i = 0; i < 16; i++) begin
            stall[i]  = 0;
            cnt_at[i] = 0;
        end
        data_valid = 1'b1;
        data       = tx_list[0];
        cnt_at[0]  = fifo_count;
        while (idx < n && guard < 5000) begin
            acc = data_ready;
            if (!acc) stall[idx]++;
            tick();
            guard++;
            if (acc) begin
                idx++;
                if (idx < n) begin
                    data        = tx_list[idx];
                    cnt_at[idx] = fifo_count;
                end
            end
        end
        data_valid = 1'b0;
        chk({nm, " bytes accepted"}, idx, n);
    endtask

    task automatic wait_idle(input string nm);
        int run;
        int g;
        run = 0;
        g   = 0;
        while (run < 3 && g < 3000) begin
            tick();
            g++;
            if (tx_busy === 1'b0 && fifo_count === 3'd0 && uart_txd === 1'b1) run++;
            else run = 0;
        end
        chk_ok({nm, " reached idle"}, g < 3000, g, "under 3000 cycles");
    endtask

    task automatic check_rx(input int n, input string nm);
        chk({nm, " rx count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) chk($sformatf("%s rx byte %0d", nm, i), rx_q[i], tx_list[i]);
        end
    endtask

    initial begin : main
        int busy_lo;
        int lows;
        int highs;

        vecs[0] = '{8'hA5, 10'b0101001011};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'h3C, 10'b0001111001};
        vecs[4] = '{8'h81, 10'b0100000011};

        rst        = 1'b1;
        data_valid = 1'b0;
        data       = 8'h00;
        repeat (2) tick();
        chk("reset txd", uart_txd, 1);
        chk("reset busy", tx_busy, 0);
        chk("reset count", fifo_count, 0);
        chk("ready in reset", data_ready, 0);
        data_valid = 1'b1;
        data       = 8'hEE;
        tick();
        chk("push ignored in reset", fifo_count, 0);
        data_valid = 1'b0;
        rst        = 1'b0;
        tick();
        chk("ready after reset", data_ready, 1);
        chk("idle txd", uart_txd, 1);

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].dat, vecs[v].line, $sformatf("frame_%02h", vecs[v].dat));
            repeat (3) tick();
        end

        // Back-to-back frames: 0x00, 0xFF, 0x55
        rx_q.delete();
        rx_start.delete();
        tx_list[0] = 8'h00;
        tx_list[1] = 8'hFF;
        tx_list[2] = 8'h55;
        stream(3, "b2b");
        chk("b2b count after push1", cnt_at[1], 1);
        chk("b2b count after push2", cnt_at[2], 1);
        busy_lo = 0;
        for (int k = 3; k <= 82; k++) begin
            if (k == 3)  chk("b2b count after push3", fifo_count, 2);
            if (k == 41) chk("b2b count before 1st boundary", fifo_count, 2);
            if (k == 42) chk("b2b count after 1st boundary", fifo_count, 1);
            if (k == 82) chk("b2b count after 2nd boundary", fifo_count, 0);
            if (tx_busy !== 1'b1) busy_lo++;
            if (k < 82) tick();
        end
        chk("b2b busy gaps", busy_lo, 0);
        wait_idle("b2b");
        check_rx(3, "b2b");
        if (rx_start.size() >= 3) begin
            chk("b2b gap 1", rx_start[1] - rx_start[0], 10 * CPB);
            chk("b2b gap 2", rx_start[2] - rx_start[1], 10 * CPB);
        end

        // FIFO full: 0x10..0x17 offered continuously
        rx_q.delete();
        for (int i = 0; i < 8; i++) tx_list[i] = 8'h10 + 8'(i);
        stream(8, "full");
        chk("full no stall before 0x15", stall[4], 0);
        chk("full count when 0x15 offered", cnt_at[5], 4);
        chk_ok("full 0x15 stall cycles", stall[5] >= 36 && stall[5] <= 37, stall[5], "36 or 37");
        wait_idle("full");
        check_rx(8, "full");

        // Push on the same edge as a STOP->START pop
        rx_q.delete();
        tx_list[0] = 8'h5A;
        tx_list[1] = 8'hC3;
        tx_list[2] = 8'h7E;
        tx_list[3] = 8'h01;
        stream(3, "simul");
        repeat (38) tick();
        chk("simul count before", fifo_count, 2);
        data_valid = 1'b1;
        data       = tx_list[3];
        tick();
        data_valid = 1'b0;
        chk("simul count after push+pop", fifo_count, 2);
        wait_idle("simul");
        check_rx(4, "simul");

        // Reset during data bit 3 of the first frame
        rx_q.delete();
        tx_list[0] = 8'h11;
        tx_list[1] = 8'h22;
        tx_list[2] = 8'h33;
        stream(3, "midrst");
        repeat (17) tick();
        chk("midrst txd in bit3", uart_txd, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst txd", uart_txd, 1);
        chk("midrst busy", tx_busy, 0);
        chk("midrst count", fifo_count, 0);
        lows  = 0;
        highs = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (uart_txd !== 1'b1) lows++;
            if (tx_busy !== 1'b0) highs++;
        end
        chk("midrst line stays idle", lows, 0);
        chk("midrst busy stays low", highs, 0);
        chk("midrst nothing received", rx_q.size(), 0);
        run_frame(vecs[3].dat, vecs[3].line, "midrst_3c");
        repeat (3) tick();
        tx_list[0] = 8'h3C;
        check_rx(1, "midrst");

        // Ten bytes through the 4-entry FIFO
        rx_q.delete();
        tx_list[0] = 8'h01; tx_list[1] = 8'h80; tx_list[2] = 8'h7F; tx_list[3] = 8'hFE;
        tx_list[4] = 8'h42; tx_list[5] = 8'hBD; tx_list[6] = 8'h99; tx_list[7] = 8'h66;
        tx_list[8] = 8'hE7; tx_list[9] = 8'h18;
        stream(10, "wrap");
        wait_idle("wrap");
        check_rx(10, "wrap");

        chk("framing errors", framing_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
